// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU execution stage.
//   op_t      - 3-bit operation code (ADD..LSL)
//   state_t   - sequencing states of alu_core
//   ALU_WIDTH - default operand width
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MUL = 3'd5,
    OP_DIV = 3'd6,
    OP_LSL = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative unsigned multiply (shift-add) / divide (restoring).
// One bit is processed per step; WIDTH steps complete an operation.
// Ports:
//   clk, rstn     - clock, async active-low reset
//   load_i        - capture operands and initialise the accumulator
//   step_i        - perform one iteration
//   div_i         - 1: divide, 0: multiply (must stay stable from load to last step)
//   a_i, b_i      - operands (a = multiplicand/dividend, b = multiplier/divisor)
//   product_o     - accumulator value after the step currently being taken
//   quotient_o    - low half of that value (quotient when dividing)
//   remainder_o   - high half of that value (remainder when dividing)
module alu_muldiv_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic [WIDTH-1:0]   quotient_o,
  output logic [WIDTH-1:0]   remainder_o
);

  // acc_q holds {partial product, remaining multiplier bits} when multiplying
  // and {partial remainder, dividend/quotient bits} when dividing.
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;

  logic [WIDTH:0]     mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_sub;
  logic               div_fits;
  logic [2*WIDTH-1:0] div_nxt;

  always_comb begin
    mul_addend = acc_q[0] ? {1'b0, opnd_q} : '0;
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + mul_addend;
    // Carry out of the add shifts into the top bit.
    mul_nxt    = {mul_sum, acc_q[WIDTH-1:1]};

    div_shift  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_fits   = div_shift >= {1'b0, opnd_q};
    // When the subtract is taken the difference is below the divisor, so
    // the low WIDTH bits carry the whole value.
    div_sub    = div_shift[WIDTH-1:0] - opnd_q;
    div_nxt    = div_fits ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                          : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    acc_d      = div_i ? div_nxt : mul_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      opnd_q <= '0;
      acc_q  <= '0;
    end else if (load_i) begin
      opnd_q <= div_i ? b_i : a_i;
      acc_q  <= {{WIDTH{1'b0}}, (div_i ? a_i : b_i)};
    end else if (step_i) begin
      acc_q  <= acc_d;
    end
  end

  assign product_o   = acc_d;
  assign quotient_o  = acc_d[WIDTH-1:0];
  assign remainder_o = acc_d[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_core.sv
// alu_core: execution stage with op register, single-cycle logic/arith ops,
// iterative MUL/DIV, registered result and status flags.
//
// state | meaning
// IDLE  | waiting for start; op_load accepted
// ITER  | MUL/DIV iterating, cnt_q counts remaining steps
// DONE  | result/flags just written, done pulse high
//
// Ports:
//   clk, rstn          - clock, async active-low reset
//   op_load, op_sel    - latch op code (IDLE only)
//   start              - begin operation on a, b (IDLE only)
//   a, b               - operands
//   busy, done         - handshake (busy while not IDLE, done one cycle)
//   op                 - latched op code for display
//   result             - registered 2*WIDTH result
//   flag_z/c/v/n/e     - zero, carry/borrow, overflow, negative, div-by-zero
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               op_load,
  input  logic [2:0]         op_sel,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2:0]         op,
  output logic [2*WIDTH-1:0] result,
  output logic               flag_z,
  output logic               flag_c,
  output logic               flag_v,
  output logic               flag_n,
  output logic               flag_e
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state_q;
  op_t                op_q;
  op_t                opc_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] result_q;
  logic               z_q, c_q, v_q, n_q, e_q;
  logic               busy_q, done_q;

  op_t                eff_op;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [WIDTH-1:0]   lsl_w;
  logic [2*WIDTH-1:0] sc_res_d;
  logic               sc_c_d, sc_v_d;

  logic               md_load, md_step, md_div;
  logic [2*WIDTH-1:0] md_prod;
  logic [WIDTH-1:0]   md_quo, md_rem;
  logic [2*WIDTH-1:0] md_res;

  // A same-cycle op_load bypasses the op register.
  assign eff_op = op_load ? op_t'(op_sel) : op_q;

  always_comb begin
    sum_w    = {1'b0, a} + {1'b0, b};
    diff_w   = {1'b0, a} - {1'b0, b};
    lsl_w    = a << b[2:0];
    sc_res_d = '0;
    sc_c_d   = 1'b0;
    sc_v_d   = 1'b0;
    case (eff_op)
      OP_ADD: begin
        sc_res_d = {{(WIDTH-1){1'b0}}, sum_w};
        sc_c_d   = sum_w[WIDTH];
        sc_v_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res_d = {{WIDTH{1'b0}}, diff_w[WIDTH-1:0]};
        sc_c_d   = diff_w[WIDTH];
        sc_v_d   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  sc_res_d = {{WIDTH{1'b0}}, a & b};
      OP_OR:   sc_res_d = {{WIDTH{1'b0}}, a | b};
      OP_XOR:  sc_res_d = {{WIDTH{1'b0}}, a ^ b};
      OP_LSL:  sc_res_d = {{WIDTH{1'b0}}, lsl_w};
      default: sc_res_d = '0;
    endcase
  end

  // In IDLE the mode follows the op about to be captured; afterwards it
  // follows the captured op so a later op_load cannot disturb iteration.
  assign md_div  = (state_q == ST_IDLE) ? (eff_op == OP_DIV) : (opc_q == OP_DIV);
  assign md_load = (state_q == ST_IDLE) && start &&
                   ((eff_op == OP_MUL) || ((eff_op == OP_DIV) && (b != '0)));
  assign md_step = (state_q == ST_ITER);
  assign md_res  = (opc_q == OP_DIV) ? {md_rem, md_quo} : md_prod;

  alu_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk         (clk),
    .rstn        (rstn),
    .load_i      (md_load),
    .step_i      (md_step),
    .div_i       (md_div),
    .a_i         (a),
    .b_i         (b),
    .product_o   (md_prod),
    .quotient_o  (md_quo),
    .remainder_o (md_rem)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      opc_q    <= OP_ADD;
      cnt_q    <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
      e_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (op_load) op_q <= op_t'(op_sel);
          if (start) begin
            opc_q  <= eff_op;
            busy_q <= 1'b1;
            if (md_load) begin
              state_q <= ST_ITER;
              cnt_q   <= CW'(WIDTH);
            end else if (eff_op == OP_DIV) begin
              // Divide by zero short-circuits straight to completion.
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              result_q <= '1;
              z_q      <= 1'b0;
              c_q      <= 1'b0;
              v_q      <= 1'b0;
              n_q      <= 1'b0;
              e_q      <= 1'b1;
            end else begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              result_q <= sc_res_d;
              z_q      <= (sc_res_d == '0);
              c_q      <= sc_c_d;
              v_q      <= sc_v_d;
              n_q      <= sc_res_d[WIDTH-1];
              e_q      <= 1'b0;
            end
          end
        end
        ST_ITER: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
            result_q <= md_res;
            z_q      <= (md_res == '0);
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            n_q      <= 1'b0;
            e_q      <= 1'b0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign op     = op_q;
  assign result = result_q;
  assign flag_z = z_q;
  assign flag_c = c_q;
  assign flag_v = v_q;
  assign flag_n = n_q;
  assign flag_e = e_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed self-checking bench for alu_core (WIDTH = 8).
module tb_alu_core;

  logic        clk;
  logic        rstn;
  logic        op_load;
  logic [2:0]  op_sel;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [2:0]  op;
  logic [15:0] result;
  logic        flag_z, flag_c, flag_v, flag_n, flag_e;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  alu_core #(.WIDTH(8)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .op_load (op_load),
    .op_sel  (op_sel),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .op      (op),
    .result  (result),
    .flag_z  (flag_z),
    .flag_c  (flag_c),
    .flag_v  (flag_v),
    .flag_n  (flag_n),
    .flag_e  (flag_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic checkb(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_op(input logic [2:0] v);
    op_load = 1'b1;
    op_sel  = v;
    tick();
    op_load = 1'b0;
  endtask

  task automatic start_op(input logic [7:0] va, input logic [7:0] vb);
    a     = va;
    b     = vb;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs a fixed window after edge 0 of a multi-cycle op, measuring busy
  // cycles and the done pulse. inj=0 pulses start mid-op, inj=1 pulses
  // op_load(XOR) mid-op. The result must not move before completion.
  task automatic run_iter(input int inj, input logic [15:0] prev, input string tag,
                          output int busy_cyc, output int done_at, output int done_cnt);
    busy_cyc = 0;
    done_at  = 0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        done_at = busy_cyc;
      end
      if (i == 2) check({tag, " result held"}, result, prev);
      if (i == 3) begin
        if (inj == 0) begin
          start = 1'b1;
          a     = 8'h01;
          b     = 8'h01;
        end else begin
          op_load = 1'b1;
          op_sel  = 3'd4;
        end
      end
      tick();
      start   = 1'b0;
      op_load = 1'b0;
    end
  endtask

  int bc, da, dc;
  int done_seen;

  initial begin
    rstn    = 1'b0;
    op_load = 1'b0;
    op_sel  = 3'd0;
    start   = 1'b0;
    a       = 8'h00;
    b       = 8'h00;
    #12;
    check("rst result", result, 16'h0000);
    check("rst op", {13'b0, op}, 16'd0);
    checkb("rst busy", busy, 1'b0);
    checkb("rst done", done, 1'b0);
    checkb("rst z", flag_z, 1'b0);
    checkb("rst e", flag_e, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // ADD 0xFF + 0x01
    start_op(8'hFF, 8'h01);
    check("add result", result, 16'h0100);
    checkb("add c", flag_c, 1'b1);
    checkb("add z", flag_z, 1'b0);
    checkb("add v", flag_v, 1'b0);
    checkb("add n", flag_n, 1'b0);
    checkb("add done", done, 1'b1);
    checkb("add busy", busy, 1'b1);
    tick();
    checkb("add done once", done, 1'b0);
    checkb("add busy end", busy, 1'b0);

    // SUB
    load_op(3'd1);
    check("sub op", {13'b0, op}, 16'd1);
    start_op(8'h10, 8'h20);
    check("sub1 result", result, 16'h00F0);
    checkb("sub1 c", flag_c, 1'b1);
    checkb("sub1 n", flag_n, 1'b1);
    checkb("sub1 v", flag_v, 1'b0);
    tick();
    start_op(8'h80, 8'h01);
    check("sub2 result", result, 16'h007F);
    checkb("sub2 v", flag_v, 1'b1);
    checkb("sub2 c", flag_c, 1'b0);
    checkb("sub2 n", flag_n, 1'b0);
    tick();

    // MUL 0xFF * 0xFF with a stray start while busy
    load_op(3'd5);
    start_op(8'hFF, 8'hFF);
    run_iter(0, 16'h007F, "mul", bc, da, dc);
    check("mul busy cycles", 16'(bc), 16'd9);
    check("mul done cycle", 16'(da), 16'd9);
    check("mul done count", 16'(dc), 16'd1);
    check("mul result", result, 16'hFE01);
    checkb("mul z", flag_z, 1'b0);
    checkb("mul c", flag_c, 1'b0);
    checkb("mul busy end", busy, 1'b0);

    // DIV 100 / 7 with op_load(XOR) while busy
    load_op(3'd6);
    start_op(8'h64, 8'h07);
    run_iter(1, 16'hFE01, "div", bc, da, dc);
    check("div busy cycles", 16'(bc), 16'd9);
    check("div done cycle", 16'(da), 16'd9);
    check("div result", result, 16'h020E);
    check("div op unchanged", {13'b0, op}, 16'd6);
    checkb("div e", flag_e, 1'b0);

    // DIV by zero
    start_op(8'h12, 8'h00);
    check("div0 result", result, 16'hFFFF);
    checkb("div0 e", flag_e, 1'b1);
    checkb("div0 done", done, 1'b1);
    checkb("div0 z", flag_z, 1'b0);
    checkb("div0 n", flag_n, 1'b0);
    tick();
    checkb("div0 busy end", busy, 1'b0);

    // op_load + start bypass: XOR
    op_load = 1'b1;
    op_sel  = 3'd4;
    start_op(8'hAA, 8'hFF);
    op_load = 1'b0;
    check("xor result", result, 16'h0055);
    check("xor op", {13'b0, op}, 16'd4);
    checkb("xor e cleared", flag_e, 1'b0);
    checkb("xor done", done, 1'b1);
    tick();

    // LSL bypass: 0x81 << 3 keeps low byte 0x08
    op_load = 1'b1;
    op_sel  = 3'd7;
    start_op(8'h81, 8'h03);
    op_load = 1'b0;
    check("lsl result", result, 16'h0008);
    checkb("lsl n", flag_n, 1'b0);
    tick();

    // MUL aborted by reset during iteration 4
    load_op(3'd5);
    start_op(8'h0F, 8'h0F);
    tick();
    tick();
    tick();
    rstn = 1'b0;
    #1;
    check("abort result", result, 16'h0000);
    check("abort op", {13'b0, op}, 16'd0);
    checkb("abort busy", busy, 1'b0);
    checkb("abort done", done, 1'b0);
    checkb("abort z", flag_z, 1'b0);
    tick();
    rstn = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) done_seen++;
      tick();
    end
    check("abort no done", 16'(done_seen), 16'd0);

    start_op(8'h02, 8'h03);
    check("post add result", result, 16'h0005);
    checkb("post add done", done, 1'b1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Execution stage that sits directly downstream of the operand-entry logic. It consumes the captured operand registers A and B and a latched operation code.
- Produces a registered 16-bit result plus status flags for the ss3..ss0 display and the LEDs.
- Single-cycle logic/arithmetic ops; multi-cycle shift-add multiply and restoring divide.
- start/busy/done handshake, so the top level can trigger from a debounced pushbutton pulse.

Parameters:
WIDTH, 8, operand width; result is 2*WIDTH bits.

Ports:
clk  input  1  system clock (hz100 at top level)
rstn  input  1  asynchronous active-low reset
op_load  input  1  one-cycle pulse: latch op_sel into the operation register
op_sel  input  3  operation code to latch
start  input  1  one-cycle pulse: begin operation on a, b
a  input  WIDTH  operand A
b  input  WIDTH  operand B
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse: result/flags just updated
op  output  3  current latched operation (for display)
result  output  2*WIDTH  registered result
flag_z  output  1  result == 0 (full width)
flag_c  output  1  carry (ADD) / borrow (SUB)
flag_v  output  1  signed overflow (ADD/SUB)
flag_n  output  1  result[WIDTH-1] for ops 0-4,7; 0 for MUL/DIV
flag_e  output  1  divide-by-zero error

Behaviour:
- Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 DIV, 7 LSL (a << b[2:0], low WIDTH bits kept).
- Reset (async, rstn low):
  - state IDLE; op=0; result=0; all flags 0; busy=0; done=0.
  - Reset mid-operation aborts it with no done pulse.
- Op register:
  - op_load in IDLE latches op_sel; op_load while busy is ignored.
  - op_load and start in the same IDLE cycle: the operation uses the new op_sel (bypass), and op updates.
- Operand capture: start is sampled only in IDLE ("edge 0"); a, b and the effective op are copied into internal registers. start while busy is ignored.
- FSM states: IDLE, ITER, DONE.
- Single-cycle ops (0-4, 7):
  - At edge 0: result, flags written; state -> DONE.
  - done=1 and busy=1 for the following cycle; next edge -> IDLE.
  - Latency 1 cycle.
- ADD: result = zero-extended (WIDTH+1)-bit sum; flag_c = sum[WIDTH]; flag_v = signed overflow of the low WIDTH bits.
- SUB: result = {0, (a-b) mod 2^WIDTH}; flag_c = 1 iff a<b (unsigned); flag_v = signed overflow.
- AND/OR/XOR/LSL: upper WIDTH bits 0; flag_c = flag_v = 0.
- MUL (unsigned shift-add):
  - At edge 0: state -> ITER, iteration counter = WIDTH.
  - Edges 1..WIDTH: one iteration each, counter decrements.
  - At edge WIDTH: result = a*b; state -> DONE.
  - done is high in the cycle after edge WIDTH; busy high for WIDTH+1 cycles.
- DIV (unsigned restoring):
  - Same timing as MUL.
  - result = {remainder, quotient} (remainder in upper WIDTH bits).
- DIV with b==0: at edge 0 go directly to DONE; result = all ones; flag_e=1; latency 1.
- flag_e is cleared on every other completion.
- MUL/DIV: flag_c = flag_v = flag_n = 0.
- flag_z is computed from the final full-width result on every completion.
- result and flags hold their values between completions. The intermediate datapath is internal; the result port changes only at completion.
- The counter never wraps: ITER exits when the counter reaches 0.

Decomposition:
- Package alu_pkg:
  - op_t enum (ADD..LSL, 3 bits).
  - state_t enum (IDLE, ITER, DONE).
  - WIDTH default constant.
- Sub-module alu_muldiv_iter: the iterative multiply/divide datapath with load, step, mode, product/quotient/remainder outputs.
- alu_core holds the FSM, op register, single-cycle ops and flags.

Test Plan:
- ADD a=0xFF b=0x01 -> one cycle after start: result=0x0100, flag_c=1, flag_z=0, done pulses once.
- op_load SUB then start with a=0x10 b=0x20 -> result=0x00F0, flag_c=1, flag_n=1, flag_v=0. Then a=0x80 b=0x01 -> result=0x007F, flag_v=1.
- MUL a=0xFF b=0xFF -> busy high exactly 9 cycles, done in the 9th cycle, result=0xFE01, flag_z=0. start pulses during busy are ignored.
- DIV a=0x64 b=0x07 -> result=0x020E after 9 cycles. DIV a=0x12 b=0x00 -> result=0xFFFF, flag_e=1, done 1 cycle after start.
- MUL a=0x0F b=0x0F, assert rstn=0 at iteration 4 -> immediately result=0, flags=0, op=ADD, no done pulse. Subsequent ADD 0x02+0x03 -> 0x0005.
- op_load(XOR) during a busy DIV -> op unchanged. op_load(XOR) with start in IDLE, a=0xAA b=0xFF -> result=0x0055, op=4.
